// File: rtl/rsa_host_mem_pkg.sv
// Shared definitions for the RSA host memory: FSM states, operand region
// bases, store geometry and core status codes.
package rsa_host_mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_KICK = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam int unsigned STORE_WORDS = 256;
   localparam int unsigned STORE_AW    = 8;
   localparam int unsigned WORD_W      = 32;

   localparam logic [7:0] PT_BASE  = 8'd0;
   localparam logic [7:0] KEY_BASE = 8'd64;
   localparam logic [7:0] MOD_BASE = 8'd128;

   localparam logic [1:0] CORE_ST_IDLE = 2'b00;
   localparam logic [1:0] CORE_ST_BUSY = 2'b01;
   localparam logic [1:0] CORE_ST_FIN  = 2'b11;

   // Host writes reach the operand store only while the core is not running.
   function automatic logic host_writable(state_t s);
      return (s == ST_IDLE) || (s == ST_DONE);
   endfunction

endpackage

// File: rtl/rsa_host_mem_if.sv
// Core-side bus between the host memory (slave) and the RSA core (master).
interface rsa_host_mem_if;

   logic        core_en;
   logic [7:0]  core_addr;
   logic [31:0] core_data;
   logic        core_exe;
   logic        core_mode;
   logic [31:0] core_result;
   logic        core_o_en;
   logic [1:0]  core_status;

   modport slave (
      input  core_en, core_addr, core_result, core_o_en, core_status,
      output core_data, core_exe, core_mode
   );

   modport master (
      output core_en, core_addr, core_result, core_o_en, core_status,
      input  core_data, core_exe, core_mode
   );

endinterface

// File: rtl/rsa_host_mem_word_ram.sv
// Word RAM: one write port, one registered read port. A read and a write to
// the same address in one cycle return the old word.
module rsa_word_ram #(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned AW    = 8,
   parameter int unsigned DW    = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] rdata_d;
   logic [DW-1:0] rdata_q;

   // Array write; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Read data follows the addressed word when enabled, otherwise holds.
   always_comb begin
      rdata_d = rdata_q;
      if (re) rdata_d = mem[raddr];
   end

   // Read data register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdata_q <= '0;
      else        rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/rsa_host_mem.sv
// RSA host memory: operand store served to the core, run-control FSM and
// result capture buffer read back by the host.
module rsa_host_mem
   import rsa_host_mem_pkg::*;
#(
   parameter int unsigned NWORDS = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        host_wen,
   input  logic [7:0]  host_waddr,
   input  logic [31:0] host_wdata,
   input  logic        host_start,
   input  logic        host_mode,
   input  logic [5:0]  host_raddr,
   output logic [31:0] host_rdata,
   rsa_host_mem_if.slave core,
   output logic        busy,
   output logic        done,
   output logic [6:0]  res_count,
   output logic        err_ovf,
   output logic        err_wr
);

   localparam int unsigned RAW  = $clog2(NWORDS);
   localparam logic [6:0]  FULL = 7'(NWORDS);

   state_t      state_d, state_q;
   logic        core_exe_d, core_exe_q;
   logic        core_mode_d, core_mode_q;
   logic        busy_d, busy_q;
   logic        done_d, done_q;
   logic [6:0]  res_count_d, res_count_q;
   logic        err_ovf_d, err_ovf_q;
   logic        err_wr_d, err_wr_q;
   logic        store_we;
   logic        res_we;

   logic [31:0] res_mem [NWORDS];

   rsa_word_ram #(
      .DEPTH (STORE_WORDS),
      .AW    (STORE_AW),
      .DW    (WORD_W)
   ) u_store (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (store_we),
      .waddr (host_waddr),
      .wdata (host_wdata),
      .re    (core.core_en),
      .raddr (core.core_addr),
      .rdata (core.core_data)
   );

   // Next-state, flag and capture logic; outputs are registered from the
   // next state so they line up with the state they describe.
   always_comb begin
      state_d     = state_q;
      core_mode_d = core_mode_q;
      res_count_d = res_count_q;
      err_ovf_d   = err_ovf_q;
      err_wr_d    = err_wr_q;
      res_we      = 1'b0;
      store_we    = host_wen && host_writable(state_q);

      if (host_wen && !host_writable(state_q)) err_wr_d = 1'b1;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (host_start) begin
               state_d     = ST_KICK;
               core_mode_d = host_mode;
               res_count_d = '0;
               err_ovf_d   = 1'b0;
               err_wr_d    = 1'b0;
            end
         end
         ST_KICK: state_d = ST_RUN;
         ST_RUN: begin
            if (core.core_o_en) begin
               if (res_count_q < FULL) begin
                  res_we      = 1'b1;
                  res_count_d = res_count_q + 7'd1;
               end else begin
                  err_ovf_d = 1'b1;
               end
            end
            if (core.core_status == CORE_ST_FIN) state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase

      core_exe_d = (state_d == ST_KICK);
      busy_d     = (state_d == ST_KICK) || (state_d == ST_RUN);
      done_d     = (state_d == ST_DONE);
   end

   // Control state and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         core_exe_q  <= 1'b0;
         core_mode_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         res_count_q <= '0;
         err_ovf_q   <= 1'b0;
         err_wr_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         core_exe_q  <= core_exe_d;
         core_mode_q <= core_mode_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         res_count_q <= res_count_d;
         err_ovf_q   <= err_ovf_d;
         err_wr_q    <= err_wr_d;
      end
   end

   // Result buffer write; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (res_we) res_mem[res_count_q[RAW-1:0]] <= core.core_result;
   end

   assign host_rdata     = res_mem[host_raddr];
   assign core.core_exe  = core_exe_q;
   assign core.core_mode = core_mode_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign res_count      = res_count_q;
   assign err_ovf        = err_ovf_q;
   assign err_wr         = err_wr_q;

endmodule
